// File: rtl/dmg_pkg.sv
`default_nettype none
// ============================================================================
// Package  : dmg_pkg
// Brief    : Shared DMG bus constants, OAM DMA state type and address helpers.
// Revision : 1.0 - initial release
// ============================================================================
package dmg_pkg;

  localparam logic [15:0] ADDR_DMA     = 16'hFF46;
  localparam logic [15:0] ADDR_IO_LO   = 16'hFF00;
  localparam logic [15:0] ADDR_HRAM_HI = 16'hFFFE;
  localparam int          OAM_LEN      = 160;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    XFER  = 2'd2
  } dma_state_t;

  // Echo RAM (E000-FDFF) mirrors WRAM, so the DMA source page folds down.
  function automatic logic [7:0] dma_addr_fold(input logic [7:0] base, input logic fold_en);
    return (fold_en && (base >= 8'hE0)) ? (base & 8'hDF) : base;
  endfunction

  function automatic logic in_io_hram(input logic [15:0] addr);
    return (addr >= ADDR_IO_LO) && (addr <= ADDR_HRAM_HI);
  endfunction

endpackage
`default_nettype wire

// File: rtl/oam_dma_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : oam_dma_ctrl
// Brief    : FF46 OAM DMA engine and CPU/DMA system-bus arbiter.
//            Define OAM_DMA_BUS_LOCK_EN to block CPU reads outside IO/HRAM.
// Revision : 1.0 - initial release
// ============================================================================
module oam_dma_ctrl
  import dmg_pkg::*;
#(
  parameter int XFER_LEN    = OAM_LEN,
  parameter int START_DELAY = 1,
  parameter int ECHO_FOLD   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_write,
  input  logic [7:0]  cpu_d_out,
  input  logic [7:0]  bus_rd_data,
  output logic [15:0] bus_addr,
  output logic        bus_write,
  output logic        dma_active,
  output logic [7:0]  oam_dma_addr,
  output logic [7:0]  oam_dma_data,
  output logic        oam_dma_write,
  output logic [7:0]  dma_reg_rd,
  output logic        cpu_rd_block
);

  localparam logic [7:0] c_last_idx  = 8'(XFER_LEN - 1);
  localparam logic [7:0] c_start_dly = 8'(START_DELAY);

  generate
    if ((XFER_LEN < 1) || (XFER_LEN > 256)) begin : g_len_check
      $error("oam_dma_ctrl: XFER_LEN must be in 1..256");
    end
    if ((START_DELAY < 0) || (START_DELAY > 255)) begin : g_dly_check
      $error("oam_dma_ctrl: START_DELAY must be in 0..255");
    end
  endgenerate

  dma_state_t r_state;
  logic [7:0] r_base;
  logic [7:0] r_idx;
  logic [7:0] r_delay;
  logic       r_oam_write;
  logic [7:0] r_oam_addr;
  logic [7:0] r_oam_data;

  logic       w_trigger;
  logic       w_xfer;
  logic       w_cpu_io;
  logic [7:0] w_src_hi;

  assign w_trigger = ce && cpu_write && (cpu_addr == ADDR_DMA);
  assign w_xfer    = (r_state == XFER);
  assign w_cpu_io  = in_io_hram(cpu_addr);
  assign w_src_hi  = dma_addr_fold(r_base, ECHO_FOLD != 0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_base      <= 8'hFF;
      r_idx       <= 8'h00;
      r_delay     <= 8'h00;
      r_oam_write <= 1'b0;
      r_oam_addr  <= 8'h00;
      r_oam_data  <= 8'h00;
    end else begin
      r_oam_write <= 1'b0;
      if (ce) begin
        if (w_xfer) begin
          r_oam_write <= 1'b1;
          r_oam_addr  <= r_idx;
          r_oam_data  <= bus_rd_data;
          r_idx       <= r_idx + 8'd1;
          if (r_idx == c_last_idx) begin
            r_state <= IDLE;
          end
        end else if (r_state == DELAY) begin
          if (r_delay <= 8'd1) begin
            r_delay <= 8'h00;
            r_state <= XFER;
          end else begin
            r_delay <= r_delay - 8'd1;
          end
        end
        // A retrigger overrides the sequencing above; the in-flight byte still lands.
        if (w_trigger) begin
          r_base  <= cpu_d_out;
          r_idx   <= 8'h00;
          r_delay <= c_start_dly;
          if (START_DELAY == 0) begin
            r_state <= XFER;
          end else begin
            r_state <= DELAY;
          end
        end
      end
    end
  end

  assign bus_addr      = w_xfer ? {w_src_hi, r_idx} : cpu_addr;
  assign bus_write     = cpu_write && (!w_xfer || w_cpu_io);
  assign dma_active    = w_xfer;
  assign oam_dma_write = r_oam_write;
  assign oam_dma_addr  = r_oam_addr;
  assign oam_dma_data  = r_oam_data;
  assign dma_reg_rd    = r_base;

`ifdef OAM_DMA_BUS_LOCK_EN
  assign cpu_rd_block = w_xfer && !w_cpu_io;
`else
  assign cpu_rd_block = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_oam_dma_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_oam_dma_ctrl
// Brief    : Self-checking bench for oam_dma_ctrl against a transfer-list model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_oam_dma_ctrl;

  localparam int XFER_LEN    = 160;
  localparam int START_DELAY = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic        cpu_write = 1'b0;
  logic [7:0]  cpu_d_out = 8'h00;
  wire  [7:0]  bus_rd_data;
  logic [15:0] bus_addr;
  logic        bus_write;
  logic        dma_active;
  logic [7:0]  oam_dma_addr;
  logic [7:0]  oam_dma_data;
  logic        oam_dma_write;
  logic [7:0]  dma_reg_rd;
  logic        cpu_rd_block;

  logic [7:0] mem [0:65535];
  assign bus_rd_data = mem[bus_addr];

  always #5 clk = ~clk;

  oam_dma_ctrl #(.XFER_LEN(XFER_LEN), .START_DELAY(START_DELAY), .ECHO_FOLD(1)) dut (
    .clk(clk), .rst(rst), .ce(ce),
    .cpu_addr(cpu_addr), .cpu_write(cpu_write), .cpu_d_out(cpu_d_out),
    .bus_rd_data(bus_rd_data), .bus_addr(bus_addr), .bus_write(bus_write),
    .dma_active(dma_active), .oam_dma_addr(oam_dma_addr), .oam_dma_data(oam_dma_data),
    .oam_dma_write(oam_dma_write), .dma_reg_rd(dma_reg_rd), .cpu_rd_block(cpu_rd_block)
  );

  // One entry per expected OAM write: M-cycle index, OAM slot, source address.
  typedef struct {
    int          m;
    logic [7:0]  idx;
    logic [15:0] src;
  } xfer_t;

  xfer_t exp_q[$];
  int m_count = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int n_wr_seen = 0;
  int first_wr_m = -1;
  int n_active = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] src_page(input logic [7:0] b);
    if (b >= 8'hE0) return b - 8'h20;
    return b;
  endfunction

  function automatic logic in_io(input logic [15:0] a);
    return (a >= 16'hFF00) && (a <= 16'hFFFE);
  endfunction

  // A trigger at M-cycle t cancels everything scheduled after t and queues a full copy.
  task automatic model_trigger(input int t, input logic [7:0] b);
    xfer_t e;
    while (exp_q.size() > 0 && exp_q[exp_q.size()-1].m > t) void'(exp_q.pop_back());
    for (int i = 0; i < XFER_LEN; i++) begin
      e.m   = t + 1 + START_DELAY + i;
      e.idx = 8'(i);
      e.src = {src_page(b), 8'(i)};
      exp_q.push_back(e);
    end
  endtask

  task automatic find(input int cur, output bit hit, output xfer_t e);
    hit   = 1'b0;
    e.m   = 0;
    e.idx = 8'h00;
    e.src = 16'h0000;
    while (exp_q.size() > 0 && exp_q[0].m < cur) void'(exp_q.pop_front());
    if (exp_q.size() > 0 && exp_q[0].m == cur) begin
      hit = 1'b1;
      e   = exp_q[0];
    end
  endtask

  // One M-cycle (4 clks), entered and left on a negedge.
  task automatic mcycle(input bit inject_rst);
    bit          hit;
    xfer_t       e;
    int          cur;
    logic [15:0] exp_ba;
    logic        exp_bw;
    logic        exp_blk;
    logic [7:0]  exp_data;
    cur = m_count;
    find(cur, hit, e);
    ce = 1'b1;
    #1;
    exp_ba   = hit ? e.src : cpu_addr;
    exp_bw   = cpu_write && (!hit || in_io(cpu_addr));
    exp_data = mem[e.src];
`ifdef OAM_DMA_BUS_LOCK_EN
    exp_blk = hit && !in_io(cpu_addr);
`else
    exp_blk = 1'b0;
`endif
    chk("dma_active", 16'(dma_active), 16'(hit));
    chk("bus_addr", bus_addr, exp_ba);
    chk("bus_write", 16'(bus_write), 16'(exp_bw));
    chk("cpu_rd_block", 16'(cpu_rd_block), 16'(exp_blk));
    if (dma_active === 1'b1) n_active++;
    @(negedge clk);
    ce = 1'b0;
    if (exp_bw) mem[cpu_addr] = cpu_d_out;
    m_count++;
    chk("oam_write", 16'(oam_dma_write), 16'(hit));
    if (hit) begin
      chk("oam_addr", 16'(oam_dma_addr), 16'(e.idx));
      chk("oam_data", 16'(oam_dma_data), 16'(exp_data));
    end
    if (oam_dma_write === 1'b1) begin
      n_wr_seen++;
      if (first_wr_m < 0) first_wr_m = cur;
    end
    if (inject_rst) begin
      rst = 1'b1;
      #1;
      chk("rst_oam_write", 16'(oam_dma_write), 16'h0);
      chk("rst_oam_addr", 16'(oam_dma_addr), 16'h0);
      chk("rst_oam_data", 16'(oam_dma_data), 16'h0);
      chk("rst_dma_active", 16'(dma_active), 16'h0);
      chk("rst_dma_reg_rd", 16'(dma_reg_rd), 16'h00FF);
      chk("rst_bus_addr", bus_addr, cpu_addr);
      exp_q.delete();
    end
    @(negedge clk);
    chk("oam_write_width", 16'(oam_dma_write), 16'h0);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
    cpu_addr  = a;
    cpu_d_out = d;
    cpu_write = 1'b1;
    if (a == 16'hFF46) model_trigger(m_count, d);
    mcycle(1'b0);
    cpu_write = 1'b0;
  endtask

  // Random CPU traffic; with_writes adds random writes anywhere except FF46.
  task automatic run(input int n, input bit with_writes);
    for (int k = 0; k < n; k++) begin
      case ($urandom_range(0, 3))
        0:       cpu_addr = 16'hC000;
        1:       cpu_addr = 16'hFF90;
        default: cpu_addr = 16'($urandom);
      endcase
      if (cpu_addr == 16'hFF46) cpu_addr = 16'hFF47;
      cpu_d_out = 8'($urandom);
      cpu_write = with_writes && ($urandom_range(0, 3) == 0);
      mcycle(1'b0);
      cpu_write = 1'b0;
    end
  endtask

  initial begin
    int         t;
    logic [7:0] saved;
    logic [7:0] b;

    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'hC100 + i] = 8'(i) ^ 8'h5A;

    // Reset state
    repeat (3) @(negedge clk);
    cpu_addr  = 16'h1234;
    cpu_write = 1'b1;
    #1;
    chk("reset_dma_active", 16'(dma_active), 16'h0);
    chk("reset_oam_write", 16'(oam_dma_write), 16'h0);
    chk("reset_oam_addr", 16'(oam_dma_addr), 16'h0);
    chk("reset_oam_data", 16'(oam_dma_data), 16'h0);
    chk("reset_cpu_rd_block", 16'(cpu_rd_block), 16'h0);
    chk("reset_dma_reg_rd", 16'(dma_reg_rd), 16'h00FF);
    chk("reset_bus_addr", bus_addr, 16'h1234);
    chk("reset_bus_write", 16'(bus_write), 16'h1);
    cpu_write = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run(4, 1'b0);

    // Full copy from C100 with dropped WRAM write and passed-through HRAM write
    n_wr_seen = 0; first_wr_m = -1; n_active = 0;
    saved = mem[16'hC000];
    t = m_count;
    cpu_wr(16'hFF46, 8'hC1);
    chk("dma_reg_rd_c1", 16'(dma_reg_rd), 16'h00C1);
    for (int k = 0; k < 170; k++) begin
      if (k == 10) cpu_wr(16'hC000, ~saved);
      else if (k == 20) cpu_wr(16'hFF80, 8'hA5);
      else run(1, 1'b0);
    end
    chk("first_write_latency", 16'(first_wr_m - t), 16'd2);
    chk("write_count_c1", 16'(n_wr_seen), 16'(XFER_LEN));
    chk("active_cycles_c1", 16'(n_active), 16'(XFER_LEN));
    chk("wram_c000_kept", 16'(mem[16'hC000]), 16'(saved));
    chk("hram_ff80_written", 16'(mem[16'hFF80]), 16'h00A5);

    // Restart at idx 50
    t = m_count;
    cpu_wr(16'hFF46, 8'hC0);
    run(51, 1'b0);
    n_wr_seen = 0; first_wr_m = -1;
    t = m_count;
    cpu_wr(16'hFF46, 8'hC2);
    run(170, 1'b0);
    chk("restart_inflight_at_trigger", 16'(first_wr_m - t), 16'd0);
    chk("write_count_restart", 16'(n_wr_seen), 16'(XFER_LEN + 1));
    chk("dma_reg_rd_c2", 16'(dma_reg_rd), 16'h00C2);

    // Echo fold
    cpu_wr(16'hFF46, 8'hFE);
    chk("dma_reg_rd_fe", 16'(dma_reg_rd), 16'h00FE);
    run(1, 1'b0);
    #1;
    chk("fold_first_addr", bus_addr, 16'hDE00);
    @(negedge clk);
    run(165, 1'b0);

    // Random bases with random CPU traffic
    for (int r = 0; r < 2; r++) begin
      b = 8'($urandom_range(8'hC0, 8'hFD));
      cpu_wr(16'hFF46, b);
      chk("dma_reg_rd_rand", 16'(dma_reg_rd), 16'(b));
      run(165, 1'b1);
    end

    // Reset mid-transfer, right after idx 80 is written
    cpu_wr(16'hFF46, 8'hC3);
    run(81, 1'b0);
    mcycle(1'b1);
    n_wr_seen = 0;
    run(3, 1'b0);
    rst = 1'b0;
    run(170, 1'b0);
    chk("no_writes_after_rst", 16'(n_wr_seen), 16'h0);
    chk("post_rst_dma_reg_rd", 16'(dma_reg_rd), 16'h00FF);
    chk("post_rst_idle", 16'(dma_active), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/oam_dma_ctrl.md
Name: oam_dma_ctrl

Overview:
- OAM DMA engine and system-bus arbiter for the DMG core.
- Decodes CPU writes to FF46 and copies 160 bytes from {base, 8'h00} into OAM at one byte per M-cycle.
- While copying, owns the shared bus address/write lines; the CPU is locked out of everything except IO/HRAM.
- Sits between sm83, the bus decode mux and ppu_m's OAM port, and replaces the ad-hoc dma_idx logic in the top level.

Parameters:
XFER_LEN, 160, bytes per transfer; also the OAM index limit.
START_DELAY, 1, M-cycles between the FF46 write and the first copied byte.
ECHO_FOLD, 1, 1 = base E0-FF reads fold to C0-DF (base & 8'hDF).

Ports:
clk  in  1  system clock (4x M-cycle rate)
rst  in  1  reset (see interface rule)
ce  in  1  M-cycle enable, one clk pulse per M-cycle
cpu_addr  in  16  CPU address
cpu_write  in  1  CPU write strobe
cpu_d_out  in  8  CPU write data
bus_rd_data  in  8  decoded bus read data (source byte)
bus_addr  out  16  arbitrated bus address
bus_write  out  1  arbitrated bus write
dma_active  out  1  high in XFER
oam_dma_addr  out  8  OAM write index
oam_dma_data  out  8  OAM write data
oam_dma_write  out  1  OAM write strobe, one clk wide
dma_reg_rd  out  8  FF46 readback (last written base)
cpu_rd_block  out  1  CPU read must return 8'hFF

Behaviour:
- Interface rule: one clock; reset is asynchronous and active-high.
  - Clock port is clk; reset port is rst.
  - All flops clear on rst high, independent of clk.
- Reset values:
  - state=IDLE, base=8'hFF, dma_reg_rd=8'hFF, idx=0, delay counter=0.
  - dma_active=0, oam_dma_write=0, oam_dma_addr=0, oam_dma_data=0, cpu_rd_block=0.
  - bus_addr and bus_write then follow the CPU combinationally.
- Trigger: a clk edge with ce && cpu_write && cpu_addr==16'hFF46.
  - base <= cpu_d_out; dma_reg_rd <= cpu_d_out.
  - idx <= 0; delay counter <= START_DELAY; state <= DELAY.
  - Accepted from any state. A write during DELAY or XFER restarts the transfer with the new base; the byte in flight on that ce is still written.
- States:
  - IDLE: CPU owns the bus.
  - DELAY: CPU still owns the bus. Each ce decrements the counter; on reaching 0, go to XFER. START_DELAY=0 goes straight to XFER on the next ce.
  - XFER:
    - bus_addr={src_hi, idx}, where src_hi = (ECHO_FOLD && base>=8'hE0) ? base&8'hDF : base.
    - bus_write=0, so CPU writes are dropped except to FF00-FFFE, which still decode.
    - On each ce: oam_dma_write=1 for that single clk, oam_dma_addr=idx, oam_dma_data=bus_rd_data, then idx increments.
    - On the ce that writes idx==XFER_LEN-1: go to IDLE; dma_active drops on the following clk.
- Latency: write at ce N → first OAM write at ce N+1+START_DELAY → last OAM write at ce N+START_DELAY+XFER_LEN. 161 M-cycles total at the defaults.
- idx is 8 bits. XFER_LEN ≤ 256 is enforced by an elaboration check. idx never wraps within a transfer.
- No ce in a clk cycle means no state change.
- rst asserted mid-XFER aborts immediately; no further OAM writes occur.

Optional Feature:
- Macro: OAM_DMA_BUS_LOCK_EN.
- Defined: in XFER, cpu_rd_block=1 whenever cpu_addr is outside FF00-FFFE, so the top-level mux returns 8'hFF to the CPU.
- Undefined: cpu_rd_block is tied to 0, and the CPU reads whatever the DMA source address returns (relaxed model, smaller logic).

Decomposition:
- Shared package dmg_pkg holds:
  - the address constants (ADDR_DMA=16'hFF46, HRAM/IO range bounds);
  - typedef enum logic [1:0] dma_state_t {IDLE, DELAY, XFER};
  - OAM_LEN=160.
- No sub-module needed. An optional helper, dma_addr_fold (pure combinational), computes the echo fold.

Test Plan:
- Write 8'hC1 to FF46, WRAM preloaded with C100+i=i^8'h5A → 160 OAM writes, addr 0..159, data i^5A, first write 2 ce after the trigger, dma_active high exactly 160 ce.
- Restart: write 8'hC0, then 8'hC2 at idx=50 → idx=50 still written from C0xx, then the sequence restarts at OAM 0 from C200, with 160 further writes.
- Base 8'hFE with ECHO_FOLD=1 → bus_addr runs DE00..DE9F; dma_reg_rd reads back 8'hFE.
- CPU write to C000 during XFER → bus_write=0, WRAM unchanged; CPU write to FF80 during XFER → passes through (bus_write=1 is not gated for FF80-FFFE decode).
- With OAM_DMA_BUS_LOCK_EN: cpu_addr=C000 in XFER → cpu_rd_block=1; cpu_addr=FF90 → 0. Without the macro → always 0.
- Assert rst at idx=80 → all outputs reach their reset values in the same cycle, no OAM writes after rst, and the controller is IDLE after release.
